// File: rtl/sd_pkg.sv
// Shared CRC7 constants for the SD CMD line, and a reference step function
// used by the CMD driver model.
package sd_pkg;

    localparam int          CRC7_W    = 7;
    localparam logic [6:0]  CRC7_POLY = 7'h09;
    localparam logic [6:0]  CRC7_INIT = 7'h00;

    function automatic logic [CRC7_W-1:0] crc7_step(input logic [CRC7_W-1:0] crc,
                                                    input logic              data_bit);
        logic fb;
        fb = data_bit ^ crc[CRC7_W-1];
        return {crc[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7+x^3+1) generator/checker for the SD CMD line.
// Optional sticky mismatch flag oerr is built when SD_CRC7_ERR_EN is defined.
module sd_crc7
    import sd_pkg::*;
#(
    parameter int                CRC_W = CRC7_W,
    parameter logic [CRC_W-1:0]  POLY  = CRC7_POLY,
    parameter logic [CRC_W-1:0]  INIT  = CRC7_INIT
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic idata,
    input  logic iunload,
`ifdef SD_CRC7_ERR_EN
    output logic ocrc,
    output logic oerr
`else
    output logic ocrc
`endif
);

    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crc_shift;
    logic             fb;

    assign crc_shift = {crc[CRC_W-2:0], 1'b0};
    assign fb        = idata ^ crc[CRC_W-1];
    assign ocrc      = crc[CRC_W-1];

    // Unload is a plain shift; the register drains to zero after CRC_W cycles.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            crc <= INIT;
        end else if (iunload) begin
            crc <= crc_shift;
        end else begin
            crc <= crc_shift ^ (fb ? POLY : '0);
        end
    end

`ifdef SD_CRC7_ERR_EN
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            oerr <= 1'b0;
        end else if (iunload && (idata != ocrc)) begin
            oerr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sd_crc7.sv
// Directed-vector bench for sd_crc7 with known SD command CRCs, plus a
// cycle-by-cycle random mode-toggle comparison against sd_pkg::crc7_step.
`timescale 1ns/1ps
module tb_sd_crc7;
    import sd_pkg::*;

    logic iclk = 1'b0;
    logic irst_n = 1'b0;
    logic idata = 1'b0;
    logic iunload = 1'b0;
    logic ocrc;
`ifdef SD_CRC7_ERR_EN
    logic oerr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sd_crc7 dut (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .idata   (idata),
        .iunload (iunload),
`ifdef SD_CRC7_ERR_EN
        .ocrc    (ocrc),
        .oerr    (oerr)
`else
        .ocrc    (ocrc)
`endif
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic d, input logic u);
        irst_n  = r;
        idata   = d;
        iunload = u;
        @(posedge iclk);
        #1;
    endtask

    task automatic absorb(input logic [39:0] v);
        for (int i = 39; i >= 0; i--) tick(1'b1, v[i], 1'b0);
    endtask

    // Checks ocrc against exp bit-by-bit while unloading; drives the line with
    // exp, inverting bit flip_idx (if >= 0) to provoke a mismatch.
    task automatic unload_chk(input string tag, input logic [6:0] exp, input int flip_idx);
        for (int i = 6; i >= 0; i--) begin
            chk(tag, {31'd0, ocrc}, {31'd0, exp[i]});
            tick(1'b1, (i == flip_idx) ? ~exp[i] : exp[i], 1'b1);
        end
    endtask

    logic [6:0] m;
    logic       d, u;

    initial begin
        // reset state
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("reset_ocrc", {31'd0, ocrc}, 32'd0);
`ifdef SD_CRC7_ERR_EN
        chk("reset_oerr", {31'd0, oerr}, 32'd0);
`endif

        // CMD0
        tick(1'b0, 1'b0, 1'b0);
        absorb(40'h40_00000000);
        unload_chk("cmd0", 7'h4A, -1);
        chk("drain0", {31'd0, ocrc}, 32'd0);
        tick(1'b1, 1'b0, 1'b1);
        chk("drain1", {31'd0, ocrc}, 32'd0);
        tick(1'b1, 1'b1, 1'b1);
        chk("drain2", {31'd0, ocrc}, 32'd0);

        // CMD8
        tick(1'b0, 1'b0, 1'b0);
        absorb(40'h48_000001AA);
        unload_chk("cmd8", 7'h43, -1);

        // CMD17
        tick(1'b0, 1'b0, 1'b0);
        absorb(40'h51_00000000);
        unload_chk("cmd17", 7'h2A, -1);

        // Missed leading start bit: 0x40.. with first bit dropped gives same CRC
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 38; i >= 0; i--) tick(1'b1, (i == 38), 1'b0);
        unload_chk("cmd0_nolead", 7'h4A, -1);

        // R1 receive check, line matches
        tick(1'b0, 1'b0, 1'b0);
        absorb(40'h11_00000900);
        unload_chk("r1", 7'h33, -1);
`ifdef SD_CRC7_ERR_EN
        chk("r1_oerr_clean", {31'd0, oerr}, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        absorb(40'h11_00000900);
        for (int i = 6; i >= 0; i--) begin
            chk("r1_err_pre", {31'd0, oerr}, {31'd0, (i < 3)});
            tick(1'b1, (i == 3) ? ~ocrc : ocrc, 1'b1);
        end
        chk("r1_err_sticky", {31'd0, oerr}, 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        chk("r1_err_hold", {31'd0, oerr}, 32'd1);
        tick(1'b0, 1'b1, 1'b1);
        chk("r1_err_clear", {31'd0, oerr}, 32'd0);
`endif

        // Reset after random data, then restart
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("rst_rand", {31'd0, ocrc}, 32'd0);
        absorb(40'h40_00000000);
        unload_chk("rst_rand_cmd0", 7'h4A, -1);

        // Reset mid-unload
        tick(1'b0, 1'b0, 1'b0);
        absorb(40'h48_000001AA);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("rst_unload", {31'd0, ocrc}, 32'd0);
        absorb(40'h51_00000000);
        unload_chk("rst_unload_cmd17", 7'h2A, -1);

        // Random compute/unload interleave against the reference step
        tick(1'b0, 1'b0, 1'b0);
        m = CRC7_INIT;
        for (int i = 0; i < 10000; i++) begin
            d = 1'($urandom_range(0, 1));
            u = ($urandom_range(0, 3) == 0);
            tick(1'b1, d, u);
            m = u ? {m[5:0], 1'b0} : crc7_step(m, d);
            chk("rand", {31'd0, ocrc}, {31'd0, m[6]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
